// File: rtl/be_share_arbiter.sv
// be_share_arbiter: one backend engine shared round-robin between NUM_REQ
// frontend packet writers. Start pulses and lengths are latched per frontend.
// The granted bank index and length are held for the whole backend run.
// Finish is routed back to the owner. A watchdog forces completion when the
// backend never reports done.
//
// state | meaning
// IDLE  | no packet in flight, granting the next pending frontend if any
// BUSY  | backend running on be_bank_o, waiting for be_finish_i or the watchdog
module be_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1,
   parameter int LEN_W   = 16,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NUM_REQ-1:0]       req_start_i,
   input  logic [NUM_REQ*LEN_W-1:0] req_length_i,
   output logic [NUM_REQ-1:0]       req_finish_o,
   output logic                     be_start_o,
   output logic [LEN_W-1:0]         be_length_o,
   output logic [ID_W-1:0]          be_bank_o,
   input  logic                     be_finish_i,
   output logic                     busy_o,
   output logic                     err_timeout_o,
   output logic                     err_overflow_o
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   // the last BUSY cycle before the watchdog forces completion
   localparam logic [TO_W-1:0] TIMER_TC = TO_W'(TIMEOUT - 1);

   state_t             state_q;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [LEN_W-1:0]   len_q [NUM_REQ];
   logic [ID_W-1:0]    last_grant_q;
   logic [ID_W-1:0]    grant_q;
   logic [TO_W-1:0]    timer_q;

   logic               pick_vld;
   logic [ID_W-1:0]    pick_idx;
   logic [ID_W-1:0]    cand;
   logic               grant_now;

   // Round-robin pick: the first pending index after last_grant_q wins.
   // Scanning from the farthest candidate down leaves the nearest one selected.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
         if (pending_q[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign grant_now = (state_q == ST_IDLE) && pick_vld;

   // A new start request set on the same edge as a grant clear wins.
   always_comb begin
      pending_d = pending_q;
      if (grant_now) begin
         pending_d[pick_idx] = 1'b0;
      end
      pending_d = pending_d | req_start_i;
   end

   // Latch pending requests and lengths, and flag a restart on a still-pending requester.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         pending_q      <= '0;
         err_overflow_o <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            len_q[i] <= '0;
         end
      end else begin
         pending_q <= pending_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_start_i[i]) begin
               len_q[i] <= req_length_i[i*LEN_W +: LEN_W];
               if (pending_q[i]) begin
                  err_overflow_o <= 1'b1;
               end
            end
         end
      end
   end

   // Grant/finish FSM with the watchdog and the registered backend outputs.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= ID_W'(NUM_REQ - 1);
         grant_q       <= '0;
         timer_q       <= '0;
         be_start_o    <= 1'b0;
         be_bank_o     <= '0;
         be_length_o   <= '0;
         req_finish_o  <= '0;
         err_timeout_o <= 1'b0;
      end else begin
         be_start_o    <= 1'b0;
         req_finish_o  <= '0;
         err_timeout_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  be_start_o  <= 1'b1;
                  be_bank_o   <= pick_idx;
                  be_length_o <= len_q[pick_idx];
                  grant_q     <= pick_idx;
                  timer_q     <= '0;
                  state_q     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               timer_q <= timer_q + TO_W'(1);
               // a real finish in the expiry cycle is not reported as a timeout
               if (be_finish_i || (timer_q == TIMER_TC)) begin
                  req_finish_o[grant_q] <= 1'b1;
                  err_timeout_o         <= ~be_finish_i;
                  last_grant_q          <= grant_q;
                  state_q               <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o = (state_q == ST_BUSY);

endmodule

// File: tb/tb_be_share_arbiter.sv
// Bench for be_share_arbiter: a directed cycle table, hand-written round-robin
// and watchdog sequences, and random traffic. Every cycle is also compared
// against a packet-level reference model.
module tb_be_share_arbiter;

   localparam int TIMEOUT = 4096;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [1:0]  req_start;
   logic [31:0] req_length;
   logic [1:0]  req_finish;
   logic        be_start;
   logic [15:0] be_length;
   logic [0:0]  be_bank;
   logic        be_finish;
   logic        busy;
   logic        err_timeout;
   logic        err_overflow;

   int n_vec = 0;
   int n_err = 0;

   be_share_arbiter #(
      .NUM_REQ(2), .ID_W(1), .LEN_W(16), .TO_W(16), .TIMEOUT(TIMEOUT)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .req_start_i   (req_start),
      .req_length_i  (req_length),
      .req_finish_o  (req_finish),
      .be_start_o    (be_start),
      .be_length_o   (be_length),
      .be_bank_o     (be_bank),
      .be_finish_i   (be_finish),
      .busy_o        (busy),
      .err_timeout_o (err_timeout),
      .err_overflow_o(err_overflow)
   );

   always #5 aclk = ~aclk;

   // Reference model: who owns the backend, how long it has run, and what is queued.
   bit [1:0]    m_pend;
   logic [15:0] m_len [2];
   int          m_owner;
   int          m_age;
   int          m_last;
   bit          m_start;
   bit          m_bank;
   logic [15:0] m_blen;
   bit [1:0]    m_fin;
   bit          m_to;
   bit          m_ov;

   task automatic model_step();
      bit [1:0] snap;
      int g;
      if (!aresetn) begin
         m_pend = '0; m_len[0] = '0; m_len[1] = '0;
         m_owner = -1; m_age = 0; m_last = 1;
         m_start = 0; m_bank = 0; m_blen = '0; m_fin = '0; m_to = 0; m_ov = 0;
         return;
      end
      snap = m_pend;
      m_start = 0; m_fin = '0; m_to = 0;
      if (m_owner < 0) begin
         g = -1;
         for (int d = 1; d <= 2; d++) begin
            if (g < 0 && snap[(m_last + d) % 2]) g = (m_last + d) % 2;
         end
         if (g >= 0) begin
            m_start = 1; m_bank = g[0]; m_blen = m_len[g];
            m_owner = g; m_age = 0; m_pend[g] = 0;
         end
      end else begin
         m_age++;
         if (be_finish || m_age == TIMEOUT) begin
            m_fin[m_owner] = 1'b1;
            m_to = !be_finish;
            m_last = m_owner;
            m_owner = -1;
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (req_start[i]) begin
            if (snap[i]) m_ov = 1;
            m_len[i] = req_length[i*16 +: 16];
            m_pend[i] = 1;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      model_step();
      #1;
      chk("model", {41'd0, req_finish, be_start, be_length, be_bank, busy, err_timeout, err_overflow},
          {41'd0, m_fin, m_start, m_blen, m_bank, (m_owner >= 0), m_to, m_ov});
   endtask

   task automatic wait_start(input string nm);
      for (int w = 0; w < 8 && !be_start; w++) tick();
      chk(nm, 64'(be_start), 64'd1);
   endtask

   typedef struct {
      bit          rst_n;
      bit [1:0]    rs;
      logic [15:0] l0;
      logic [15:0] l1;
      bit          fin;
      bit          e_start;
      bit          e_bank;
      logic [15:0] e_len;
      bit [1:0]    e_fin;
      bit          e_busy;
      bit          e_to;
      bit          e_ov;
   } vec_t;

   vec_t tbl [15];

   initial begin
      aresetn = 1'b0; req_start = '0; req_length = '0; be_finish = 1'b0;

      //          rst rs     l0        l1        fin  start bank len       fin    busy to ov
      tbl[0]  = '{0, 2'b00, 16'h0000, 16'h0000, 0,   0,    0,   16'h0000, 2'b00, 0,   0, 0};
      tbl[1]  = '{1, 2'b11, 16'd60,   16'd1514, 0,   0,    0,   16'h0000, 2'b00, 0,   0, 0};
      tbl[2]  = '{1, 2'b00, 16'h0000, 16'h0000, 0,   1,    0,   16'd60,   2'b00, 1,   0, 0};
      tbl[3]  = '{1, 2'b00, 16'h0000, 16'h0000, 0,   0,    0,   16'd60,   2'b00, 1,   0, 0};
      tbl[4]  = '{1, 2'b00, 16'h0000, 16'h0000, 1,   0,    0,   16'd60,   2'b01, 0,   0, 0};
      tbl[5]  = '{1, 2'b00, 16'h0000, 16'h0000, 0,   1,    1,   16'd1514, 2'b00, 1,   0, 0};
      tbl[6]  = '{1, 2'b01, 16'h05ea, 16'h0000, 0,   0,    1,   16'd1514, 2'b00, 1,   0, 0};
      tbl[7]  = '{1, 2'b00, 16'h0000, 16'h0000, 1,   0,    1,   16'd1514, 2'b10, 0,   0, 0};
      tbl[8]  = '{1, 2'b00, 16'h0000, 16'h0000, 0,   1,    0,   16'h05ea, 2'b00, 1,   0, 0};
      tbl[9]  = '{1, 2'b01, 16'h0123, 16'h0000, 0,   0,    0,   16'h05ea, 2'b00, 1,   0, 0};
      tbl[10] = '{1, 2'b01, 16'h0456, 16'h0000, 0,   0,    0,   16'h05ea, 2'b00, 1,   0, 1};
      tbl[11] = '{1, 2'b00, 16'h0000, 16'h0000, 1,   0,    0,   16'h05ea, 2'b01, 0,   0, 1};
      tbl[12] = '{1, 2'b00, 16'h0000, 16'h0000, 0,   1,    0,   16'h0456, 2'b00, 1,   0, 1};
      tbl[13] = '{0, 2'b00, 16'h0000, 16'h0000, 0,   0,    0,   16'h0000, 2'b00, 0,   0, 0};
      tbl[14] = '{1, 2'b00, 16'h0000, 16'h0000, 1,   0,    0,   16'h0000, 2'b00, 0,   0, 0};

      foreach (tbl[r]) begin
         aresetn    = tbl[r].rst_n;
         req_start  = tbl[r].rs;
         req_length = {tbl[r].l1, tbl[r].l0};
         be_finish  = tbl[r].fin;
         tick();
         chk($sformatf("row%0d", r),
             {41'd0, req_finish, be_start, be_length, be_bank, busy, err_timeout, err_overflow},
             {41'd0, tbl[r].e_fin, tbl[r].e_start, tbl[r].e_len, tbl[r].e_bank,
              tbl[r].e_busy, tbl[r].e_to, tbl[r].e_ov});
      end
      req_start = '0; be_finish = 1'b0; aresetn = 1'b1;

      // round-robin with continuous re-requests: banks must alternate from 0
      begin
         bit prev;
         aresetn = 1'b0; tick(); aresetn = 1'b1;
         req_start = 2'b11; req_length = {16'd1514, 16'd60}; tick(); req_start = '0;
         prev = 1'b1;
         for (int p = 0; p < 6; p++) begin
            wait_start($sformatf("rr_start%0d", p));
            chk($sformatf("rr_bank%0d", p), 64'(be_bank), 64'(p % 2));
            chk($sformatf("rr_alt%0d", p), 64'(be_bank != prev), 64'd1);
            prev = be_bank;
            tick(); tick();
            be_finish = 1'b1; tick(); be_finish = 1'b0;
            chk($sformatf("rr_fin%0d", p), 64'(req_finish), 64'(2'b01 << prev));
            req_start = req_finish; tick(); req_start = '0;
         end
         for (int w = 0; w < 8 && busy; w++) begin
            be_finish = 1'b1; tick(); be_finish = 1'b0;
         end
      end

      // watchdog expiry, then a late finish that must be ignored
      begin
         int k;
         aresetn = 1'b0; tick(); aresetn = 1'b1;
         req_length = {16'd100, 16'd0}; req_start = 2'b10; tick(); req_start = '0;
         wait_start("wd_start");
         chk("wd_bank", 64'(be_bank), 64'd1);
         k = 0;
         while (k < TIMEOUT + 100 && !err_timeout) begin
            tick(); k++;
         end
         chk("wd_cycles", 64'(k), 64'(TIMEOUT));
         chk("wd_fin", 64'(req_finish), 64'(2'b10));
         chk("wd_busy", 64'(busy), 64'd0);
         tick();
         chk("wd_pulse", 64'({err_timeout, req_finish}), 64'd0);
         be_finish = 1'b1; tick(); be_finish = 1'b0;
         chk("wd_late", 64'({busy, err_timeout, req_finish}), 64'd0);

         // finish landing on the expiry cycle is a normal finish
         req_start = 2'b01; tick(); req_start = '0;
         wait_start("wd2_start");
         for (int c = 0; c < TIMEOUT - 1; c++) tick();
         chk("wd2_pre", 64'({busy, err_timeout}), 64'(2'b10));
         be_finish = 1'b1; tick(); be_finish = 1'b0;
         chk("wd2_fin", 64'(req_finish), 64'(2'b01));
         chk("wd2_noto", 64'(err_timeout), 64'd0);
      end

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         aresetn    = ($urandom_range(299) != 0);
         req_start  = {($urandom_range(7) == 0), ($urandom_range(7) == 0)};
         req_length = $urandom;
         be_finish  = ($urandom_range(5) == 0);
         tick();
      end
      aresetn = 1'b1; req_start = '0; be_finish = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
